// File: rtl/pattern_tx_serializer_if.sv
// pattern_tx_serializer_if: frame request, serial line and status bundle for pattern_tx_serializer
interface pattern_tx_serializer_if #(parameter int W = 8, parameter int HW = 4);
  logic en;
  logic start;
  logic [W-1:0] data;
  logic a;
  logic busy;
  logic done;
  logic [HW-1:0] hits;
  modport master (output en, start, data, input a, busy, done, hits);
  modport slave (input en, start, data, output a, busy, done, hits);
endinterface

// File: rtl/pattern_tx_serializer.sv
// pattern_tx_serializer: shifts a word out MSB-first on en ticks and counts emitted 0->1 edges
module pattern_tx_serializer #(
  parameter int W = 8,
  parameter int HW = 4,
  parameter logic IDLE_BIT = 1'b1
) (
  input logic clk,
  input logic rst_n,
  pattern_tx_serializer_if.slave bus
);
  localparam int CW = $clog2(W);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  logic [1:0] state;
  logic [W-1:0] shreg;
  logic [CW-1:0] bitcnt;
  logic prev;
  logic done;
  logic [HW-1:0] hits;
  logic shifting;
  assign shifting = state == SHIFT;
  assign bus.a = shifting ? shreg[W-1] : IDLE_BIT;
  assign bus.busy = shifting;
  assign bus.done = done;
  assign bus.hits = hits;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      bitcnt <= '0;
      prev <= 1'b1;
      done <= 1'b0;
      hits <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          shreg <= bus.data;
          bitcnt <= '0;
          prev <= 1'b1;
          hits <= '0;
          state <= SHIFT;
        end
        SHIFT: if (bus.en) begin
          // prev starts at 1 so a leading 1 never counts; hits saturates instead of wrapping
          if (!prev && shreg[W-1] && hits != '1) hits <= hits + 1'b1;
          prev <= shreg[W-1];
          shreg <= shreg << 1;
          bitcnt <= bitcnt + 1'b1;
          if (bitcnt == CW'(W - 1)) begin
            state <= IDLE;
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pattern_tx_serializer.sv
// tb_pattern_tx_serializer: scoreboard bench; expected bits and hit counts queued at start, checked on ticks and done
module tb_pattern_tx_serializer;
  localparam int W = 8;
  localparam int HW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pattern_tx_serializer_if #(.W(W), .HW(HW)) bus();
  pattern_tx_serializer #(.W(W), .HW(HW), .IDLE_BIT(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic exp_bits[$];
  logic [HW-1:0] exp_hits[$];
  int det_cnt = 0;
  logic det_prev = 1'b1;
  int busy_cnt = 0;
  int done_cnt = 0;
  logic last_tick = 1'b0;
  logic last_hold = 1'b0;
  logic last_a = 1'b1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  function automatic logic [HW-1:0] model_hits(input logic [W-1:0] d);
    logic p = 1'b1;
    logic [HW-1:0] h = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!p && d[i] && h != '1) h = h + 1'b1;
      p = d[i];
    end
    return h;
  endfunction
  // reference detector samples a on every en tick, including idle ones
  always @(negedge clk) begin
    if (!rst_n) det_prev = 1'b1;
    else if (bus.en) begin
      if (!det_prev && bus.a) det_cnt++;
      det_prev = bus.a;
    end
    if (bus.busy) busy_cnt++;
    if (bus.busy && last_hold) check("a_hold", bus.a, last_a);
    if (bus.busy && bus.en) begin
      if (exp_bits.size() == 0) check("extra_bit", 1, 0);
      else check("a_bit", bus.a, exp_bits.pop_front());
    end
    if (!bus.busy) check("idle_a", bus.a, 1);
    if (bus.done) begin
      done_cnt++;
      check("done_lat", last_tick, 1);
      check("done_busy", bus.busy, 0);
      if (exp_hits.size() == 0) check("spurious_done", 1, 0);
      else check("hits", bus.hits, exp_hits.pop_front());
    end
    last_tick = bus.busy && bus.en;
    last_hold = bus.busy && !bus.en;
    last_a = bus.a;
  end
  task automatic send(input logic [W-1:0] d);
    for (int i = W - 1; i >= 0; i--) exp_bits.push_back(d[i]);
    exp_hits.push_back(model_hits(d));
    bus.data = d;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("first_bit", bus.a, d[W-1]);
    check("busy_start", bus.busy, 1);
    check("done_clr", bus.done, 0);
  endtask
  task automatic run(input int per, input bit mid);
    int c = 0;
    bit ok = 1'b0;
    for (int k = 0; k < per * W + 10; k++) begin
      bus.en = (c % per == 0);
      bus.start = mid && c == 3;
      if (bus.start) bus.data = '0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      c++;
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
    bus.en = 1'b0;
    check("frame_done", ok, 1);
    if (!ok) begin
      exp_bits.delete();
      exp_hits.delete();
    end
  endtask
  task automatic idle(input int n);
    bus.en = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    bus.en = 1'b0;
  endtask
  task automatic check_rst(input string tag);
    check({tag, "_a"}, bus.a, 1);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_hits"}, bus.hits, 0);
  endtask
  initial begin
    int d0;
    int n0;
    bus.en = 1'b0;
    bus.start = 1'b0;
    bus.data = '0;
    repeat (4) begin
      bus.start = 1'($urandom);
      bus.en = 1'($urandom);
      @(posedge clk);
      #1;
      check_rst("rst");
    end
    bus.start = 1'b0;
    rst_n = 1'b1;
    repeat (3) begin
      bus.en = 1'($urandom);
      @(posedge clk);
      #1;
      check_rst("post_rst");
    end
    bus.en = 1'b0;
    d0 = det_cnt;
    busy_cnt = 0;
    done_cnt = 0;
    send(8'b0101_0101);
    run(1, 1'b0);
    idle(3);
    check("det55", det_cnt - d0, 4);
    check("busy55", busy_cnt, 8);
    check("done55_once", done_cnt, 1);
    d0 = det_cnt;
    send(8'hFF);
    run(1, 1'b0);
    idle(2);
    check("detFF", det_cnt - d0, 0);
    d0 = det_cnt;
    send(8'h00);
    run(1, 1'b0);
    check("hold_hits00", bus.hits, 0);
    idle(3);
    check("det00_trailing", det_cnt - d0, 1);
    send(8'b0000_0001);
    run(1, 1'b0);
    idle(1);
    check("hits01_hold", bus.hits, 1);
    send(8'b0011_0110);
    run(3, 1'b0);
    idle(1);
    check("hits36_hold", bus.hits, 2);
    done_cnt = 0;
    send(8'hC3);
    run(1, 1'b1);
    send(8'hA5);
    run(1, 1'b0);
    idle(1);
    check("b2b_done", done_cnt, 2);
    check("hitsA5_hold", bus.hits, 3);
    send(8'h96);
    bus.en = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check_rst("mid_rst");
    exp_bits.delete();
    exp_hits.delete();
    n0 = done_cnt;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.en = 1'b0;
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("mid_rst_no_done", done_cnt, n0);
    send(8'h3C);
    run(1, 1'b0);
    idle(2);
    check("clean_done", done_cnt, n0 + 1);
    check("clean_hits", bus.hits, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pattern_tx_serializer.md
Name: pattern_tx_serializer

Overview:
Transmit-side counterpart to the team's serial "0-then-1" Moore pattern detector. It loads a parallel word and shifts it out MSB-first on the single-bit line `a`, one bit per `en` tick, using the same tick the detector uses. It also counts the 0→1 transitions it emits (`hits`), so a bench or system can compare the count against the detector's `y` pulses.

Parameters:
W, 8, frame width in bits (≥2).
HW, 4, width of `hits` counter; must satisfy 2^HW > W/2.
IDLE_BIT, 1'b1, level driven on `a` when no frame is active.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
en  input  1  bit-tick enable; shared with the detector's en.
start  input  1  frame request; sampled only in IDLE.
data  input  W  frame word, captured on accepted start.
a  output  1  serial bit line to the detector.
busy  output  1  high while a frame is being shifted.
done  output  1  one-cycle pulse after the last bit is consumed.
hits  output  HW  0→1 transitions emitted in the current or last frame.

Behaviour:
- Single clock `clk`. Reset is asynchronous, active-low (`rst_n`); all state is cleared while `rst_n` = 0.
- Reset values:
  - state = IDLE
  - `a` = IDLE_BIT
  - `busy` = 0
  - `done` = 0
  - `hits` = 0
  - internal shift register = 0, bit counter = 0, prev = 1
- States: IDLE, SHIFT. Two bits of state encoding; illegal encodings return to IDLE.
- IDLE:
  - `a` = IDLE_BIT; `en` is ignored.
  - `start` = 1 at a clock edge: shreg <= `data`, bitcnt <= 0, prev <= 1, `hits` <= 0, go to SHIFT.
  - Start does not require `en`.
- SHIFT:
  - `busy` = 1; `a` = shreg[W-1], combinational from the register with no extra delay.
  - `en` = 0: everything holds and `a` stays stable. Gaps of any length are legal.
  - `en` = 1 (the edge where the detector samples `a`):
    - If prev = 0 and `a` = 1, `hits` <= `hits` + 1.
    - prev <= `a`.
    - shreg <= shreg << 1.
    - bitcnt <= bitcnt + 1.
  - `en` = 1 with bitcnt = W-1: the last bit is consumed; go to IDLE and assert `done` for exactly one cycle.
- Latency:
  - First bit appears on `a` the cycle after start is accepted.
  - A frame occupies exactly W `en` ticks.
  - `done` rises one cycle after the edge on which the W-th tick is sampled.
- `hits`:
  - Holds its final value in IDLE until the next accepted start.
  - Saturates at 2^HW-1; it never wraps.
- `start` while busy is ignored, not queued.
- `start` in the `done` cycle (state already IDLE) is accepted, giving back-to-back frames.
- The first bit of a frame counts as a hit only if it follows an emitted 0 within the same frame; prev is 1 at frame start, so a leading 1 never counts.
- Boundary, trailing 0: if the frame ends in 0 and IDLE_BIT = 1, the detector sees one extra 0→1 edge after the frame. This edge is intentionally NOT counted in `hits`.
- Reset mid-frame: the frame is aborted immediately, all outputs return to reset values, and no `done` pulse is produced.

Test Plan:
- Reset: hold `rst_n` = 0 with random `start`/`en` → `a`=1, `busy`=0, `done`=0, `hits`=0; release `rst_n` → outputs unchanged until `start`.
- W=8, `data`=8'b0101_0101, `en`=1 every cycle → `a` sequence 0,1,0,1,0,1,0,1; `busy` high 8 cycles; `done` 1-cycle pulse; `hits`=4; a detector on the same `en` pulses `y` 4 times.
- `data`=8'hFF → `hits`=0; `data`=8'h00 → `hits`=0, with exactly one post-frame detector hit when IDLE_BIT=1; `data`=8'b0000_0001 → `hits`=1.
- `en` every 3rd cycle, `data`=8'b0011_0110 → `a` holds 3 cycles per bit; `hits`=2; `done` one cycle after the 8th tick edge.
- `start` pulsed mid-frame → ignored, frame completes unchanged; `start` in the `done` cycle with `data`=8'hA5 → new frame begins next cycle with `a`=1, final `hits`=3.
- Reset asserted after 3 of 8 bits → `busy`=0, `a`=1, `hits`=0 immediately; no `done` pulse; next `start` runs a full clean frame.
